uart_rx_fifo: RTL

- UART receive front-end placed directly upstream of top_alu_interface.
- Deserialises the rx line using the 16x oversampling baud tick and buffers complete bytes in a small FIFO.
- Exposes the FIFO to the ALU interface through the r_data / rx_empty / rd_uart handshake that the interface already consumes.
- Also reports framing and overrun errors.

---
 rtl/uart_rx_fifo_if.sv | 41 ++++
 rtl/uart_rx_fifo.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Groups the tick / serial-line / pop / error signals of uart_rx_fifo.
//   slave  modport : used by the receiver (uart_rx_fifo)
//   master modport : used by whoever drives the line and pops bytes
// Signals:
//   i_s_tick     16x baud tick pulse
//   i_rx         serial line, idles high
//   i_rd_uart    pop request from the consumer
//   i_clr_err    clear sticky error flags
//   o_r_data     FIFO head byte (valid while o_rx_empty = 0)
//   o_rx_empty   FIFO empty
//   o_rx_full    FIFO full
//   o_frame_err  sticky framing error
//   o_overrun    sticky overrun
//   o_parity_err sticky parity error (0 unless UART_RX_PARITY_EN)
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int DBIT = 8
);
    logic            i_s_tick;
    logic            i_rx;
    logic            i_rd_uart;
    logic            i_clr_err;
    logic [DBIT-1:0] o_r_data;
    logic            o_rx_empty;
    logic            o_rx_full;
    logic            o_frame_err;
    logic            o_overrun;
    logic            o_parity_err;

    modport slave (
        input  i_s_tick, i_rx, i_rd_uart, i_clr_err,
        output o_r_data, o_rx_empty, o_rx_full, o_frame_err, o_overrun, o_parity_err
    );

    modport master (
        output i_s_tick, i_rx, i_rd_uart, i_clr_err,
        input  o_r_data, o_rx_empty, o_rx_full, o_frame_err, o_overrun, o_parity_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver (16x oversampling) feeding a first-word-fall-through FIFO.
// Completed bytes are pushed into the FIFO; the consumer pops with rd_uart.
// Framing and overrun errors are reported as sticky flags.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit (sticky o_parity_err).
//
// Ports:
//   clock   system clock, rising edge
//   i_reset asynchronous active-low reset
//   bus     uart_rx_fifo_if.slave (tick, rx, pop, clear, data and flags)
// Parameters:
//   DBIT    data bits per frame
//   SB_TICK ticks spanned by the stop bit (16/24/32)
//   ADDR_W  FIFO address width, depth = 2**ADDR_W
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int ADDR_W  = 2
) (
    input  logic              clock,
    input  logic              i_reset,
    uart_rx_fifo_if.slave     bus
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int TICK_W = $clog2((SB_TICK > 16) ? SB_TICK : 16);
    localparam int BIT_W  = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // receiver state
    state_t             state_q, state_d;
    logic [TICK_W-1:0]  s_q, s_d;
    logic [BIT_W-1:0]   n_q, n_d;
    logic [DBIT-1:0]    b_q, b_d;
    logic               rx_meta_q, rx_sync_q;
    logic               done_s;
    logic               frame_err_set_s;
    logic               parity_err_set_s;
`ifdef UART_RX_PARITY_EN
    logic               par_q, par_d;
    logic               parity_err_q, parity_err_d;
`endif

    // FIFO state
    logic [DBIT-1:0]    mem_q [DEPTH];
    logic [DBIT-1:0]    mem_d [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic [DBIT-1:0]    r_data_q, r_data_d;
    logic               push_s, pop_s, overrun_set_s;

    // sticky errors
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.i_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver next-state logic; counters only move on a baud tick.
    always_comb begin
        state_d          = state_q;
        s_d              = s_q;
        n_d              = n_q;
        b_d              = b_q;
        done_s           = 1'b0;
        frame_err_set_s  = 1'b0;
        parity_err_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d            = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    s_d     = '0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bus.i_s_tick) begin
                    // Tick 7 is the middle of the start bit: confirm it is still low.
                    if (s_q == TICK_W'(7)) begin
                        if (!rx_sync_q) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + TICK_W'(1);
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bus.i_s_tick) begin
                    if (s_q == TICK_W'(15)) begin
                        s_d = '0;
                        // LSB-first: shift new bits in at the top.
                        b_d = {rx_sync_q, b_q[DBIT-1:1]};
                        if (n_q == BIT_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + BIT_W'(1);
                        end
                    end else begin
                        s_d = s_q + TICK_W'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bus.i_s_tick) begin
                    if (s_q == TICK_W'(15)) begin
                        s_d     = '0;
                        par_d   = rx_sync_q;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + TICK_W'(1);
                    end
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bus.i_s_tick) begin
                    if (s_q == TICK_W'(SB_TICK - 1)) begin
                        state_d = ST_IDLE;
                        if (!rx_sync_q) begin
                            frame_err_set_s = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if ((^b_q) ^ par_q) begin
                            parity_err_set_s = 1'b1;
`endif
                        end else begin
                            done_s = 1'b1;
                        end
                    end else begin
                        s_d = s_q + TICK_W'(1);
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                n_d     = '0;
            end
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // A pop only counts when there is something to pop, so a simultaneous
    // push into an empty FIFO degenerates to a plain push; a pop frees the
    // slot a push into a full FIFO needs, so no overrun in that case.
    always_comb begin
        pop_s         = bus.i_rd_uart & ~empty_q;
        push_s        = done_s & (~full_q | pop_s);
        overrun_set_s = done_s & full_q & ~pop_s;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        empty_d       = empty_q;
        full_d        = full_q;
        case ({push_s, pop_s})
            2'b10: begin
                mem_d[wr_ptr_q] = b_q;
                wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
                empty_d         = 1'b0;
                full_d          = ((wr_ptr_q + ADDR_W'(1)) == rd_ptr_q);
            end
            2'b01: begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                full_d   = 1'b0;
                empty_d  = ((rd_ptr_q + ADDR_W'(1)) == wr_ptr_q);
            end
            2'b11: begin
                mem_d[wr_ptr_q] = b_q;
                wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
                rd_ptr_d        = rd_ptr_q + ADDR_W'(1);
            end
            default: begin
                empty_d = empty_q;
            end
        endcase
        // Registered head: shows the entry the read pointer will point at.
        r_data_d = mem_d[rd_ptr_d];
    end

    // FIFO storage, pointers and status registers.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            r_data_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            r_data_q <= r_data_d;
        end
    end

    // Sticky error next state: a new error in the clear cycle wins.
    always_comb begin
        frame_err_d  = (frame_err_q & ~bus.i_clr_err) | frame_err_set_s;
        overrun_d    = (overrun_q & ~bus.i_clr_err) | overrun_set_s;
`ifdef UART_RX_PARITY_EN
        parity_err_d = (parity_err_q & ~bus.i_clr_err) | parity_err_set_s;
`endif
    end

    // Sticky error registers.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.o_r_data    = r_data_q;
    assign bus.o_rx_empty  = empty_q;
    assign bus.o_rx_full   = full_q;
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_err = parity_err_q;
`else
    // Parity-set is never raised without the parity state.
    logic unused_parity_s;
    assign unused_parity_s  = parity_err_set_s;
    assign bus.o_parity_err = 1'b0;
`endif

endmodule
